// File: rtl/imem_loader.sv
// Instruction memory loader: zeroes the RAM, then fills it from a length-prefixed
// byte stream and holds the processor in reset until the program is complete.
module imem_loader #(
  parameter int N     = 32,
  parameter int DEPTH = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         reload,
  input  logic [6:0]   addr,
  output logic [N-1:0] q,
  output logic         cpu_reset,
  output logic         done,
  output logic         err,
  output logic [7:0]   words_loaded
);

  // state | meaning
  // CLEAR | sweep zeroes into the RAM, one word per cycle
  // IDLE  | waiting for the length byte
  // LOAD  | assembling 4-byte little-endian words into the RAM
  // DONE  | program loaded, processor released, input ignored
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DONE} state_t;

  state_t state, state_next;

  logic [6:0]   clr_addr;
  logic [1:0]   byte_cnt;
  logic [23:0]  asm_buf;
  logic [7:0]   target;
  logic [N-1:0] mem [DEPTH];

  logic         accept;
  logic         last_word;
  logic [31:0]  word_full;
  logic         we;
  logic [6:0]   waddr;
  logic [N-1:0] wdata;

  assign accept    = in_valid && in_ready;
  assign word_full = {in_data, asm_buf};
  assign last_word = (words_loaded + 8'd1) == target;
  assign q         = mem[addr];

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    we         = 1'b0;
    waddr      = clr_addr;
    wdata      = '0;
    case (state)
      CLEAR: begin
        we = 1'b1;
        if (clr_addr == 7'(DEPTH - 1)) state_next = IDLE;
      end
      IDLE: begin
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        if (accept && byte_cnt == 2'd3) begin
          we    = 1'b1;
          waddr = words_loaded[6:0];
          wdata = N'(word_full);
          if (last_word) state_next = DONE;
        end
      end
      DONE: begin
        if (reload) state_next = CLEAR;
      end
      default: state_next = CLEAR;
    endcase
  end

  // The RAM has no reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr     <= '0;
      byte_cnt     <= '0;
      asm_buf      <= '0;
      target       <= '0;
      words_loaded <= '0;
      err          <= 1'b0;
      in_ready     <= 1'b0;
      done         <= 1'b0;
      cpu_reset    <= 1'b1;
    end else begin
      // Handshake/status outputs are flops decoded from the next state.
      in_ready  <= (state_next == IDLE) || (state_next == LOAD);
      done      <= (state_next == DONE);
      cpu_reset <= (state_next != DONE);
      case (state)
        CLEAR: clr_addr <= clr_addr + 7'd1;
        IDLE: begin
          if (accept) begin
            target       <= (in_data == 8'd0 || in_data > 8'(DEPTH)) ? 8'(DEPTH) : in_data;
            err          <= in_data > 8'(DEPTH);
            byte_cnt     <= '0;
            words_loaded <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) words_loaded <= words_loaded + 8'd1;
            else                  asm_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
          end
        end
        DONE: begin
          if (reload) begin
            clr_addr     <= '0;
            byte_cnt     <= '0;
            words_loaded <= '0;
            err          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter N, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 128, number of instruction words; address width is 7 bits.
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_data  input  8  program byte stream.
REQ-007 Port in_valid  input  1  in_data valid.
REQ-008 Port in_ready  output  1  loader can accept a byte.
REQ-009 Port reload  input  1  single-cycle request to restart loading from DONE.
REQ-010 Port addr  input  7  processor fetch word address.
REQ-011 Port q  output  N  instruction word at addr (combinational read).
REQ-012 Port cpu_reset  output  1  holds processor in reset while not DONE.
REQ-013 Port done  output  1  program fully loaded.
REQ-014 Port err  output  1  sticky length-saturation flag.
REQ-015 Port words_loaded  output  8  count of words written this load (0..128).

Function
REQ-016 The block SHALL hold a DEPTH x N RAM; q SHALL equal RAM[addr] combinationally in every state.
REQ-017 States: CLEAR, IDLE, LOAD, DONE; a byte is accepted on a rising edge where in_valid && in_ready.
REQ-018 in_ready SHALL be 1 in IDLE and LOAD, and 0 in CLEAR and DONE.
REQ-019 CLEAR: write 0 to one address per cycle, 0 through 127 ascending; the edge writing 127 SHALL move to IDLE (128 cycles total).
REQ-020 IDLE: the accepted byte is the length L; L=0 or L>128 SHALL mean 128 words, and L>128 SHALL set err; then go to LOAD.
REQ-021 LOAD: bytes assemble little-endian (first byte -> bits 7:0, fourth -> bits 31:24) via a 2-bit byte counter.
REQ-022 The edge accepting the 4th byte SHALL write the word to RAM[words_loaded], increment words_loaded, and reset the byte counter to 0.
REQ-023 Write addresses SHALL start at 0 for each load and stop at the word count; words beyond it keep their CLEAR value of 0.
REQ-024 The edge writing the final word SHALL enter DONE; after that edge done=1 and cpu_reset=0.
REQ-025 cpu_reset SHALL be 1 and done 0 in CLEAR, IDLE and LOAD; outputs SHALL be registered and free of combinational glitches from in_valid.
REQ-026 Read during write to the same address: q SHALL show old data in the write cycle and new data after the edge.
REQ-027 In DONE, in_data and in_valid SHALL be ignored; reload=1 SHALL enter CLEAR at the next edge, clear err, zero words_loaded, and set cpu_reset=1.
REQ-028 reload SHALL be ignored outside DONE.
REQ-029 in_valid gaps mid-word SHALL stall assembly without losing partial bytes.

Reset
REQ-030 reset=1 SHALL force CLEAR with clear address 0, byte counter 0, words_loaded=0, err=0, done=0, cpu_reset=1, in_ready=0, from any state including mid-LOAD.
REQ-031 RAM contents are not cleared by reset itself; the CLEAR sweep after reset release zeroes them.

Verification
REQ-032 Release reset, hold in_valid=1 -> in_ready stays 0 for exactly 128 cycles, then 1; q=0 at addr 0..127.
REQ-033 Send L=2, then bytes 01 00 00 F8, 02 80 00 F8 -> RAM[0]=32'hf8000001, RAM[1]=32'hf8008002, words_loaded=2, done=1, cpu_reset=0; addr=2 gives q=0.
REQ-034 Send L=0 with 512 bytes, in_valid toggling every other cycle -> 128 words correct, done=1 only after the 512th byte, err=0.
REQ-035 Send L=200 -> err=1, exactly 128 words are accepted, then done=1 and in_ready=0.
REQ-036 Assert reset after 5 bytes of a load -> CLEAR restarts, RAM returns to 0 after 128 cycles, words_loaded=0, and a subsequent load writes from address 0.
REQ-037 In DONE, pulse reload -> the next cycle shows cpu_reset=1, done=0, err=0, and 128 cycles later in_ready=1 with RAM zeroed.
